unary_add_seq: RTL and testbench

//  Sequencer for the 10-bit unary adder. Accepts a pair of binary operands over a

---
 rtl/unary_add_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_unary_add_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_seq.sv
// unary_add_seq: drives a 10-bit unary adder through one complete operation.
// A request supplies two binary operands. The sequencer clears the adder and
// emits unary pulse trains on add_a/add_b. It then switches the adder to read
// mode and deserialises add_dout, MSB first, into a binary sum. The sum and a
// sticky overflow flag go back over a response port.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A producer holds valid and its payload stable until that edge. req_ready is
// high only in IDLE. rsp_valid is high only in RESP, and rsp_sum/rsp_ovf hold
// their values until the transfer.
//
// Every adder-facing and response output is a register. Each is loaded from
// the decode of the next state, so it changes on the same edge as the state.
module unary_add_seq #(
  parameter int WIDTH    = 10,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovf,
  // unary adder interface
  output logic             add_rst_n,
  output logic             add_en,
  output logic             add_a,
  output logic             add_b,
  output logic             add_rw,
  input  logic             add_dout,
  input  logic             add_c,
  // observability
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PHI   = 3'd2,
    S_PLO   = 3'd3,
    S_READ  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // The READ phase has READ_LAT settle cycles, then WIDTH shift cycles.
  localparam int RD_CYC = READ_LAT + WIDTH;
  localparam int RCW    = $clog2(RD_CYC + 1);
  localparam logic [RCW-1:0]   RD_LAST   = RCW'(RD_CYC - 1);
  localparam logic [RCW-1:0]   RD_SETTLE = RCW'(READ_LAT);
  localparam logic [RCW-1:0]   RD_ONE    = RCW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_cnt_a;
  logic [WIDTH-1:0] r_cnt_b;
  logic [WIDTH-1:0] r_shift;
  logic [RCW-1:0]   r_rd_cnt;

  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_ovf;
  logic             r_add_rst_n;
  logic             r_add_en;
  logic             r_add_a;
  logic             r_add_b;
  logic             r_add_rw;

  logic             w_accept;
  logic             w_pulses_left;
  logic             w_sample_c;
  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_add_rst_n;
  logic             w_add_en;
  logic             w_add_a;
  logic             w_add_b;
  logic             w_add_rw;

  assign w_accept      = req_valid && r_req_ready;
  assign w_pulses_left = (r_cnt_a != '0) || (r_cnt_b != '0);
  // add_c is meaningful only once the adder has left its reset cycle.
  assign w_sample_c    = (r_state == S_PHI) || (r_state == S_PLO) ||
                         (r_state == S_READ);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_add_rst_n = 1'b1;
    w_add_en    = 1'b0;
    w_add_a     = 1'b0;
    w_add_b     = 1'b0;
    w_add_rw    = 1'b0;

    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = w_pulses_left ? S_PHI : S_READ;
      S_PHI:   w_next = S_PLO;
      S_PLO:   w_next = w_pulses_left ? S_PHI : S_READ;
      S_READ:  if (r_rd_cnt == RD_LAST) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    case (w_next)
      S_IDLE:  w_req_ready = 1'b1;
      S_CLEAR: w_add_rst_n = 1'b0;
      S_PHI: begin
        w_add_en = 1'b1;
        // The counters still hold their pre-decrement values here.
        w_add_a  = (r_cnt_a != '0);
        w_add_b  = (r_cnt_b != '0);
      end
      S_PLO:   w_add_en = 1'b1;
      S_READ: begin
        w_add_en = 1'b1;
        w_add_rw = 1'b1;
      end
      S_RESP:  w_rsp_valid = 1'b1;
      default: w_req_ready = 1'b0;
    endcase
  end

  // Registered control outputs, loaded from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_add_rst_n <= 1'b1;
      r_add_en    <= 1'b0;
      r_add_a     <= 1'b0;
      r_add_b     <= 1'b0;
      r_add_rw    <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_add_rst_n <= w_add_rst_n;
      r_add_en    <= w_add_en;
      r_add_a     <= w_add_a;
      r_add_b     <= w_add_b;
      r_add_rw    <= w_add_rw;
    end
  end

  // Pulse counters: latched on accept, decremented on each PHI entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_cnt_a <= req_a;
        r_cnt_b <= req_b;
      end
    end else if (w_next == S_PHI) begin
      if (r_cnt_a != '0) r_cnt_a <= r_cnt_a - CNT_ONE;
      if (r_cnt_b != '0) r_cnt_b <= r_cnt_b - CNT_ONE;
    end
  end

  // READ-phase cycle counter, held at zero outside READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
    end else if (r_state == S_READ) begin
      r_rd_cnt <= r_rd_cnt + RD_ONE;
    end else begin
      r_rd_cnt <= '0;
    end
  end

  // Deserialiser: shifts add_dout in MSB first after the settle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if ((r_state == S_READ) && (r_rd_cnt >= RD_SETTLE)) begin
      r_shift <= {r_shift[WIDTH-2:0], add_dout};
    end
  end

  // Response sum: takes the last serial bit directly on the edge into RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_sum <= '0;
    end else if ((r_state == S_READ) && (w_next == S_RESP)) begin
      r_rsp_sum <= {r_shift[WIDTH-2:0], add_dout};
    end
  end

  // Sticky overflow: cleared on accept, ORs add_c during PHI/PLO/READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_ovf <= 1'b0;
    end else if (w_accept) begin
      r_rsp_ovf <= 1'b0;
    end else if (w_sample_c) begin
      r_rsp_ovf <= r_rsp_ovf | add_c;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_ovf   = r_rsp_ovf;
  assign add_rst_n = r_add_rst_n;
  assign add_en    = r_add_en;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_rw    = r_add_rw;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_unary_add_seq.sv
// Testbench for unary_add_seq with a behavioural model of the 10-bit unary adder.
module tb_unary_add_seq;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_ovf;
  logic         add_rst_n;
  logic         add_en;
  logic         add_a;
  logic         add_b;
  logic         add_rw;
  logic         add_dout;
  logic         add_c;
  logic [2:0]   dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  unary_add_seq #(.WIDTH(W), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf),
    .add_rst_n(add_rst_n), .add_en(add_en),
    .add_a(add_a), .add_b(add_b), .add_rw(add_rw),
    .add_dout(add_dout), .add_c(add_c),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Unary adder model. Each posedge with add_en counts the add_a and add_b
  // pulses, wrapping at 2^W and setting a sticky carry on the wrap. The first
  // edge that sees add_rw high loads the count, which puts the MSB on dout
  // one cycle after add_rw rose. Later edges shift the next bit out.
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_sh;
  logic         m_c;
  logic         m_rw_q;
  logic [W:0]   m_next;

  assign m_next   = {1'b0, m_cnt} + (W+1)'(add_a) + (W+1)'(add_b);
  assign add_dout = m_sh[W-1];
  assign add_c    = m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !add_rst_n) begin
      m_cnt <= '0; m_sh <= '0; m_c <= 1'b0; m_rw_q <= 1'b0;
    end else begin
      m_rw_q <= add_rw;
      if (add_en && !add_rw) begin
        m_cnt <= m_next[W-1:0];
        if (m_next[W]) m_c <= 1'b1;
      end
      if (add_rw && !m_rw_q) m_sh <= m_cnt;
      else if (add_rw)       m_sh <= {m_sh[W-2:0], 1'b0};
    end
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_sum"},   32'(rsp_sum),   0);
    chk({tag, "_rsp_ovf"},   32'(rsp_ovf),   0);
    chk({tag, "_add_rst_n"}, 32'(add_rst_n), 1);
    chk({tag, "_add_en"},    32'(add_en),    0);
    chk({tag, "_add_ab"},    32'({add_a, add_b}), 0);
    chk({tag, "_add_rw"},    32'(add_rw),    0);
  endtask

  // Driver: present a request from a negedge and wait for the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    req_a = a; req_b = b; req_valid = 1'b1; waited = 0;
    while (!req_ready && waited < 5000) begin
      @(negedge clk); waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = ~a;          // post-accept changes must be ignored
      req_b = a ^ b;
    end
  endtask

  // Monitor one operation from the cycle after accept up to the response handshake.
  task automatic collect(input string nm, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [W-1:0] esum, input logic eovf, input int elat,
                         input int hold);
    int cyc = 0; int na = 0; int nb = 0; int nr = 0; int nrdy = 0;
    logic [W-1:0] s0; logic o0; logic bad;
    rsp_ready = (hold == 0);
    @(negedge clk);
    while (!rsp_valid && cyc < 5000) begin
      if (add_a) na++;
      if (add_b) nb++;
      if (!add_rst_n) nr++;
      if (req_ready) nrdy++;
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk({nm, "_latency"},   32'(cyc), 32'(elat));
    chk({nm, "_sum"},       32'(rsp_sum), 32'(esum));
    chk({nm, "_ovf"},       32'(rsp_ovf), 32'(eovf));
    chk({nm, "_a_pulses"},  32'(na), 32'(ea));
    chk({nm, "_b_pulses"},  32'(nb), 32'(eb));
    chk({nm, "_clr_cyc"},   32'(nr), 1);
    chk({nm, "_busy_rdy"},  32'(nrdy), 0);
    if (hold > 0) begin
      s0 = rsp_sum; o0 = rsp_ovf; bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); @(negedge clk);
        if (!rsp_valid || req_ready || rsp_sum !== s0 || rsp_ovf !== o0) bad = 1'b1;
      end
      chk({nm, "_hold_stable"}, 32'(bad), 0);
      rsp_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    chk({nm, "_idle_ready"}, 32'(req_ready), 1);
    chk({nm, "_rsp_drop"},   32'(rsp_valid), 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w;
    // latency = 2*max(a,b) + 12
    vecs[0] = '{a: 3,    b: 4,   sum: 7,    ovf: 0, lat: 20};
    vecs[1] = '{a: 0,    b: 0,   sum: 0,    ovf: 0, lat: 12};
    vecs[2] = '{a: 1023, b: 3,   sum: 2,    ovf: 1, lat: 2058};
    vecs[3] = '{a: 5,    b: 9,   sum: 14,   ovf: 0, lat: 30};
    vecs[4] = '{a: 512,  b: 512, sum: 0,    ovf: 1, lat: 1036};
    vecs[5] = '{a: 1023, b: 0,   sum: 1023, ovf: 0, lat: 2058};
    vecs[6] = '{a: 100,  b: 200, sum: 300,  ovf: 0, lat: 412};

    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven operations
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      send(vecs[i].a, vecs[i].b, w);
      collect($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum,
              vecs[i].ovf, vecs[i].lat, 0);
    end

    // consumer stalls for 5 cycles after rsp_valid
    @(negedge clk);
    send(6, 1, w);
    collect("stall", 6, 1, 7, 0, 24, 5);

    // two requests held valid back to back
    @(negedge clk);
    send(2, 2, w);
    req_valid = 1'b1; req_a = 10; req_b = 0;
    collect("b2b_first", 2, 2, 4, 0, 16, 0);
    send(10, 0, w);
    chk("b2b_second_wait", 32'(w), 0);
    collect("b2b_second", 10, 0, 10, 0, 32, 0);

    // asynchronous reset in the middle of the pulse phase
    @(negedge clk);
    send(5, 5, w);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_add_a", 32'(add_a), 1);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_rst");
    send(2, 2, w);
    collect("after_rst", 2, 2, 4, 0, 16, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
